neuron_mac: RTL and testbench

Single-neuron multiply-accumulate stage that sits directly upstream of the activation (ReLU) stage. It streams Q6.10 activations and multiplies each by a locally stored Q1.7 weight. It accumulates the products onto a Q15.17 bias with signed saturation and presents one Q15.17 sum per frame of numWeight inputs to the activation stage.

---
 rtl/neuron_mac_if.sv | 30 +++
 rtl/neuron_mac.sv | 106 ++++++++++
 tb/tb_neuron_mac.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
// Stream, weight-load and result signals of the neuron multiply-accumulate stage.
// The master drives weights, bias and activations. The slave returns sums and status.
interface neuron_mac_if #(
    parameter int addrWidth   = 10,
    parameter int dataWidth   = 16,
    parameter int weightWidth = 8,
    parameter int sumWidth    = 32
);
    logic                   wEn;
    logic [addrWidth-1:0]   wAddr;
    logic [weightWidth-1:0] wData;
    logic                   biasEn;
    logic [sumWidth-1:0]    biasIn;
    logic                   inValid;
    logic [dataWidth-1:0]   inData;
    logic                   inReady;
    logic [sumWidth-1:0]    sumOut;
    logic                   sumValid;
    logic                   busy;

    modport master (
        output wEn, wAddr, wData, biasEn, biasIn, inValid, inData,
        input  inReady, sumOut, sumValid, busy
    );

    modport slave (
        input  wEn, wAddr, wData, biasEn, biasIn, inValid, inData,
        output inReady, sumOut, sumValid, busy
    );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron MAC: Q6.10 activations times stored Q1.7 weights, accumulated with
// saturation onto a Q15.17 bias, producing one sum per frame of numWeight inputs.
module neuron_mac #(
    parameter int numWeight       = 784,
    parameter int addrWidth       = 10,
    parameter int dataWidth       = 16,
    parameter int dataFracWidth   = 10,
    parameter int weightWidth     = 8,
    parameter int weightFracWidth = 7,
    parameter int sumWidth        = 32,
    parameter int sumFracWidth    = 17
) (
    input  logic         clk,
    input  logic         reset,
    neuron_mac_if.slave  bus
);
    localparam int prodWidth  = dataWidth + weightWidth;
    localparam int alignShift = sumFracWidth - dataFracWidth - weightFracWidth;

    logic signed [weightWidth-1:0] weight_mem [numWeight];

    logic [addrWidth-1:0]          count_reg;
    logic                          accept;
    logic                          count_last;

    logic                          s1_valid_reg, s1_first_reg, s1_last_reg;
    logic signed [dataWidth-1:0]   s1_data_reg;
    logic signed [weightWidth-1:0] s1_weight_reg;

    logic                          s2_valid_reg, s2_first_reg, s2_last_reg;
    logic signed [prodWidth-1:0]   s2_prod_reg;

    logic signed [sumWidth-1:0]    bias_reg;
    logic signed [sumWidth-1:0]    acc_reg;
    logic signed [sumWidth-1:0]    acc_next;
    logic                          done_reg;
    logic [sumWidth-1:0]           sum_out_reg;
    logic                          sum_valid_reg;

    assign bus.inReady = !reset && !bus.wEn;
    assign accept      = bus.inValid && bus.inReady;
    assign count_last  = (count_reg == addrWidth'(numWeight - 1));

    // Memory and datapath registers carry no reset so the array maps onto block RAM;
    // a read that collides with a write returns the previous weight.
    always_ff @(posedge clk) begin
        if (bus.wEn && (int'(bus.wAddr) < numWeight))
            weight_mem[bus.wAddr] <= bus.wData;
        s1_weight_reg <= weight_mem[count_reg];
        s1_data_reg   <= bus.inData;
        s2_prod_reg   <= prodWidth'(s1_data_reg) * prodWidth'(s1_weight_reg);
    end

    // Saturating add: overflow only when both operands share a sign the result lacks.
    always_comb begin
        logic signed [sumWidth-1:0] prod_ext;
        logic signed [sumWidth-1:0] base;
        logic signed [sumWidth-1:0] raw;
        prod_ext = sumWidth'(s2_prod_reg) <<< alignShift;
        base     = s2_first_reg ? bias_reg : acc_reg;
        raw      = base + prod_ext;
        acc_next = raw;
        if ((base[sumWidth-1] == prod_ext[sumWidth-1]) && (raw[sumWidth-1] != base[sumWidth-1]))
            acc_next = base[sumWidth-1] ? {1'b1, {(sumWidth-1){1'b0}}}
                                        : {1'b0, {(sumWidth-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg     <= '0;
            s1_valid_reg  <= 1'b0;
            s1_first_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_first_reg  <= 1'b0;
            s2_last_reg   <= 1'b0;
            bias_reg      <= '0;
            acc_reg       <= '0;
            done_reg      <= 1'b0;
            sum_out_reg   <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            if (accept)
                count_reg <= count_last ? '0 : count_reg + 1'b1;
            s1_valid_reg <= accept;
            s1_first_reg <= (count_reg == '0);
            s1_last_reg  <= count_last;
            s2_valid_reg <= s1_valid_reg;
            s2_first_reg <= s1_first_reg;
            s2_last_reg  <= s1_last_reg;
            if (bus.biasEn)
                bias_reg <= bus.biasIn;
            if (s2_valid_reg)
                acc_reg <= acc_next;
            // Completed sum passes through one output register before the activation stage.
            done_reg      <= s2_valid_reg && s2_last_reg;
            sum_valid_reg <= done_reg;
            if (done_reg)
                sum_out_reg <= acc_reg;
        end
    end

    assign bus.sumOut   = sum_out_reg;
    assign bus.sumValid = sum_valid_reg;
    assign bus.busy     = (count_reg != '0) || s1_valid_reg || s2_valid_reg || done_reg;
endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: an integer reference model queues expected sums and
// their due cycle, and a negedge monitor compares them whenever sumValid pulses.
module tb_neuron_mac;
    localparam int NW = 4;
    localparam int AW = 2;
    localparam int DW = 16;
    localparam int WW = 8;
    localparam int SW = 32;
    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -64'sh8000_0000;

    typedef struct {
        longint sum;
        int     due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    neuron_mac_if #(.addrWidth(AW), .dataWidth(DW), .weightWidth(WW), .sumWidth(SW)) bus();

    neuron_mac #(
        .numWeight(NW), .addrWidth(AW), .dataWidth(DW), .dataFracWidth(10),
        .weightWidth(WW), .weightFracWidth(7), .sumWidth(SW), .sumFracWidth(17)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    longint w_model [NW];
    longint bias_model = 0;
    longint acc_model = 0;
    int     pos_model = 0;
    exp_t   q[$];
    int     checks = 0;
    int     fails = 0;
    int     pulses = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sx(logic [31:0] v, int width);
        longint r;
        r = longint'(v) & ((64'sd1 <<< width) - 1);
        if (r[width-1]) r = r - (64'sd1 <<< width);
        return r;
    endfunction

    function automatic longint sat(longint x);
        if (x > MAXS) return MAXS;
        if (x < MINS) return MINS;
        return x;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference behaviour: each accepted input adds data*weight (exact in 2^-17 units)
    // onto bias (first of frame) or the running sum, clamped to the 32-bit signed range.
    task automatic model_accept(logic [15:0] d);
        longint base;
        base = (pos_model == 0) ? bias_model : acc_model;
        acc_model = sat(base + sx(32'(d), 16) * w_model[pos_model]);
        pos_model++;
        if (pos_model == NW) begin
            q.push_back('{sum: acc_model, due: cyc + 3});
            pos_model = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.sumValid) begin
            pulses++;
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_sum: got sumValid with sumOut 0x%0h, expected no pulse", bus.sumOut);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", sx(bus.sumOut, 32), e.sum);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic step(bit v, logic [15:0] d, bit we, int wa, logic [7:0] wd);
        bus.inValid = v;
        bus.inData  = d;
        bus.wEn     = we;
        bus.wAddr   = AW'(wa);
        bus.wData   = wd;
        @(negedge clk);
        check("inready", bus.inReady, we ? 0 : 1);
        @(posedge clk);
        #1;
        if (we) w_model[wa] = sx(32'(wd), 8);
        else if (v) model_accept(d);
        bus.inValid = 1'b0;
        bus.wEn     = 1'b0;
    endtask

    task automatic fill_weights(logic [7:0] wd);
        for (int a = 0; a < NW; a++) step(0, 16'h0, 1, a, wd);
    endtask

    task automatic write_bias(logic [31:0] b);
        bus.biasEn = 1'b1;
        bus.biasIn = b;
        @(posedge clk);
        #1;
        bus.biasEn = 1'b0;
        bias_model = sx(b, 32);
    endtask

    task automatic frame(logic [15:0] d, bit gaps);
        for (int i = 0; i < NW; i++) begin
            step(1, d, 0, 0, 8'h0);
            if (gaps) step(0, 16'h0, 0, 0, 8'h0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d sums still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.wEn = 0; bus.wAddr = '0; bus.wData = '0; bus.biasEn = 0; bus.biasIn = '0;
        bus.inValid = 0; bus.inData = '0;
        for (int a = 0; a < NW; a++) w_model[a] = 0;

        @(negedge clk);
        check("rst_inready", bus.inReady, 0);
        check("rst_sumout", bus.sumOut, 0);
        check("rst_sumvalid", bus.sumValid, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 0.5 * 1.0 * 4 onto zero bias -> 2.0
        fill_weights(8'h40);
        write_bias(32'h0);
        frame(16'h0400, 0);
        drain();

        // -1.0 * 1.0 * 4 onto 1.0 -> -3.0
        fill_weights(8'h80);
        write_bias(32'h0002_0000);
        frame(16'h0400, 0);
        drain();

        // positive then negative saturation
        fill_weights(8'h7F);
        write_bias(32'h7FF0_0000);
        frame(16'h7FFF, 0);
        drain();
        fill_weights(8'h80);
        write_bias(32'h8010_0000);
        frame(16'h7FFF, 0);
        drain();

        // two back-to-back frames, then one with bubbles; busy tracking
        fill_weights(8'h40);
        step(0, 16'h0, 1, 2, 8'hE0);
        write_bias(32'h0001_0000);
        p0 = pulses;
        frame(16'h0C00, 0);
        frame(16'hF800, 0);
        frame(16'h0200, 1);
        check("busy_active", bus.busy, 1);
        drain();
        check("busy_idle", bus.busy, 0);
        check("pulse_count", pulses - p0, 3);

        // reset mid-frame: partial sum and bias discarded, weights kept
        step(1, 16'h1000, 0, 0, 8'h0);
        step(1, 16'h1000, 0, 0, 8'h0);
        reset = 1'b1;
        acc_model = 0; pos_model = 0; bias_model = 0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_inready", bus.inReady, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        p0 = pulses;
        frame(16'h0800, 0);
        drain();
        check("after_reset_pulses", pulses - p0, 1);

        // wEn alongside inValid blocks acceptance for two cycles
        p0 = pulses;
        step(1, 16'h0400, 1, 0, 8'h20);
        step(1, 16'h0400, 1, 1, 8'hC0);
        frame(16'h0400, 0);
        drain();
        check("wen_block_pulses", pulses - p0, 1);

        // randomized frames with bubbles, weight rewrites and bias changes
        for (int f = 0; f < 12; f++) begin
            if (f % 2 == 0) begin
                drain();
                write_bias($urandom());
            end
            for (int a = 0; a < NW; a++) step(0, 16'h0, 1, a, 8'($urandom()));
            for (int k = 0; k < 8 * NW && (k < NW || pos_model != 0); k++) begin
                int r;
                r = $urandom_range(0, 7);
                if (r == 0) step($urandom_range(0, 1), 16'($urandom()), 1, $urandom_range(0, NW - 1), 8'($urandom()));
                else if (r == 1) step(0, 16'h0, 0, 0, 8'h0);
                else step(1, 16'($urandom()), 0, 0, 8'h0);
            end
            while (pos_model != 0) step(1, 16'($urandom()), 0, 0, 8'h0);
        end
        drain();
        check("final_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
